cache_nway: RTL

- Parametrised N-way set-associative, write-back, write-allocate data cache.
- Sits between the processor's word-addressed load/store port and the 128-bit block memory interface.
- Next generation of the team's 2-way cache; generalises way count and set count.
- Adds true LRU replacement, dirty-victim-only write-back, and a defined memory handshake.

---
 rtl/cache_nway.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/cache_nway.sv
// cache_nway -- N-way set-associative, write-back, write-allocate data cache.
//
// The cache sits between a word-addressed load/store port and a 128-bit
// block memory. Hits complete with zero wait. A miss picks a victim, writes it
// back only if it is dirty, then fills the block from memory. On return to
// COMPARE the request hits, so stores merge through the normal hit path.
//
// Parameters:
//   WAYS      associativity (1, 2 or 4); 1 gives a direct-mapped cache
//   SET_BITS  index width; number of sets is 2**SET_BITS (1..6)
//
// Ports:
//   clk, proc_reset              clock and synchronous active-high reset
//   proc_read, proc_write        load/store request, held while proc_stall is high
//   proc_addr[29:0]              word address {tag, index, word offset}
//   proc_wdata / proc_rdata      store data / load data (load data valid on a hit)
//   proc_stall                   high while a request is pending
//   mem_read, mem_write          block read / write-back request
//   mem_addr[27:0]               block address
//   mem_wdata / mem_rdata        128-bit block, word 3 in [127:96]
//   mem_ready                    one-cycle pulse that completes the current transfer
//
// Optional build macro CACHE_STATS_EN adds saturating 32-bit counters
// stat_reads, stat_writes, stat_misses and stat_writebacks.

module cache_nway #(
  parameter int WAYS     = 2,
  parameter int SET_BITS = 2
) (
  input  logic          clk,
  input  logic          proc_reset,
  input  logic          proc_read,
  input  logic          proc_write,
  input  logic [29:0]   proc_addr,
  input  logic [31:0]   proc_wdata,
  output logic [31:0]   proc_rdata,
  output logic          proc_stall,
  output logic          mem_read,
  output logic          mem_write,
  output logic [27:0]   mem_addr,
  output logic [127:0]  mem_wdata,
  input  logic [127:0]  mem_rdata,
  input  logic          mem_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]   stat_reads,
  output logic [31:0]   stat_writes,
  output logic [31:0]   stat_misses,
  output logic [31:0]   stat_writebacks
`endif
);

  localparam int SETS  = 1 << SET_BITS;
  localparam int TAG_W = 28 - SET_BITS;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int AGE_W = WAY_W;

  typedef enum logic [1:0] {
    COMPARE    = 2'd0,
    WRITE_BACK = 2'd1,
    ALLOCATE   = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic [WAY_W-1:0] victim_reg, victim_next;

  // Request decode
  logic [TAG_W-1:0]    req_tag;
  logic [SET_BITS-1:0] req_index;
  logic [1:0]          req_off;
  logic                req_valid;

  assign req_tag   = proc_addr[29:2+SET_BITS];
  assign req_index = proc_addr[1+SET_BITS:2];
  assign req_off   = proc_addr[1:0];
  assign req_valid = proc_read | proc_write;

  // Per set/way storage. Lookups must be combinational to give zero-wait hits.
  logic [WAYS-1:0]  valid_reg [SETS];
  logic [WAYS-1:0]  dirty_reg [SETS];
  logic [AGE_W-1:0] age_reg   [SETS][WAYS];
  logic [TAG_W-1:0] tag_mem   [SETS][WAYS];
  logic [127:0]     data_mem  [SETS][WAYS];

  // Hit detection
  logic [WAYS-1:0]  way_hit;
  logic [WAY_W-1:0] hit_way;
  logic             hit;
  logic [127:0]     hit_block;
  logic [31:0]      hit_word;

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_tag_cmp
    assign way_hit[gi] = valid_reg[req_index][gi] && (tag_mem[req_index][gi] == req_tag);
  end

  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) hit_way = WAY_W'(w);
    end
  end

  assign hit       = |way_hit;
  assign hit_block = data_mem[req_index][hit_way];
  assign hit_word  = hit_block[{req_off, 5'd0} +: 32];

  // Victim choice: oldest way, overridden by the lowest-numbered invalid way.
  // Ages form a permutation of 0..WAYS-1 within a set, so the maximum is unique.
  logic [WAY_W-1:0] victim_comb;
  logic [AGE_W-1:0] max_age;

  always_comb begin
    victim_comb = '0;
    max_age     = '0;
    if (WAYS > 1) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_reg[req_index][w] >= max_age) begin
          max_age     = age_reg[req_index][w];
          victim_comb = WAY_W'(w);
        end
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_reg[req_index][w]) victim_comb = WAY_W'(w);
    end
  end

  // Next-state and outputs
  always_comb begin
    state_next  = state_reg;
    victim_next = victim_reg;
    proc_stall  = 1'b0;
    proc_rdata  = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (state_reg)
      COMPARE: begin
        if (req_valid) begin
          if (hit) begin
            // Read+write together is treated as a write, so no load data.
            if (proc_read && !proc_write) proc_rdata = hit_word;
          end else begin
            proc_stall  = 1'b1;
            victim_next = victim_comb;
            state_next  = dirty_reg[req_index][victim_comb] ? WRITE_BACK : ALLOCATE;
          end
        end
      end
      WRITE_BACK: begin
        proc_stall = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {tag_mem[req_index][victim_reg], req_index};
        mem_wdata  = data_mem[req_index][victim_reg];
        if (mem_ready) state_next = ALLOCATE;
      end
      ALLOCATE: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        mem_addr   = proc_addr[29:2];
        if (mem_ready) state_next = COMPARE;
      end
      default: state_next = COMPARE;
    endcase
  end

  // Control state: FSM, victim, valid/dirty bits and LRU ages
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_reg  <= COMPARE;
      victim_reg <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_reg[s] <= '0;
        dirty_reg[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          age_reg[s][w] <= AGE_W'(w);
        end
      end
    end else begin
      state_reg  <= state_next;
      victim_reg <= victim_next;
      case (state_reg)
        COMPARE: begin
          if (req_valid && hit) begin
            if (proc_write) dirty_reg[req_index][hit_way] <= 1'b1;
            if (WAYS > 1) begin
              // Hit way becomes youngest; only ways younger than it move up.
              for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == hit_way)
                  age_reg[req_index][w] <= '0;
                else if (age_reg[req_index][w] < age_reg[req_index][hit_way])
                  age_reg[req_index][w] <= age_reg[req_index][w] + AGE_W'(1);
              end
            end
          end
        end
        WRITE_BACK: begin
          if (mem_ready) dirty_reg[req_index][victim_reg] <= 1'b0;
        end
        ALLOCATE: begin
          if (mem_ready) begin
            valid_reg[req_index][victim_reg] <= 1'b1;
            dirty_reg[req_index][victim_reg] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify their contents.
  always_ff @(posedge clk) begin
    if (!proc_reset) begin
      if (state_reg == COMPARE && req_valid && hit && proc_write)
        data_mem[req_index][hit_way][{req_off, 5'd0} +: 32] <= proc_wdata;
      if (state_reg == ALLOCATE && mem_ready) begin
        data_mem[req_index][victim_reg] <= mem_rdata;
        tag_mem[req_index][victim_reg]  <= req_tag;
      end
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      stat_reads      <= '0;
      stat_writes     <= '0;
      stat_misses     <= '0;
      stat_writebacks <= '0;
    end else begin
      if (state_reg == COMPARE && req_valid) begin
        if (hit) begin
          if (proc_write) begin
            if (stat_writes != '1) stat_writes <= stat_writes + 32'd1;
          end else begin
            if (stat_reads != '1) stat_reads <= stat_reads + 32'd1;
          end
        end else begin
          if (stat_misses != '1) stat_misses <= stat_misses + 32'd1;
        end
      end
      if (state_reg == WRITE_BACK && mem_ready) begin
        if (stat_writebacks != '1) stat_writebacks <= stat_writebacks + 32'd1;
      end
    end
  end
`endif

endmodule
